tune_addr_gen: RTL and testbench

TUNE_ADDR_GEN -- requirements
Module: tune_addr_gen

---
 rtl/tune_addr_gen.sv | 146 ++++++++++++++
 tb/tb_tune_addr_gen.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/tune_addr_gen.sv
// rtl/tune_addr_gen.sv - sine-table ROM address generator for tone/rest notes
//
// Accepts a note descriptor (div = cycles per address step, len = number of
// complete table periods) and walks the ROM address 0..TABLE_LEN-1 once per
// period. div==0 is a rest: timing uses REST_DIV, addr is held at 0 and mute
// is raised while the note plays.
//
// Ports:
//   clk           clock, rising edge
//   rst_n         asynchronous active-low reset
//   note_valid    upstream note descriptor present
//   note_ready    block accepts a note this cycle (IDLE and out of reset)
//   note_div[16]  cycles per address step, 0 = rest
//   note_len[16]  note duration in complete table periods
//   abort         synchronous request to drop the current note
//   addr[9]       registered ROM address
//   step          one-cycle pulse in the cycle addr takes a new value
//   sample_valid  step delayed one cycle, aligned with the ROM output register
//   mute          high while a rest note plays
//   playing       high while in PLAY
module tune_addr_gen #(
    parameter int TABLE_LEN = 213,
    parameter int REST_DIV  = 200
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        note_valid,
    output logic        note_ready,
    input  logic [15:0] note_div,
    input  logic [15:0] note_len,
    input  logic        abort,
    output logic [8:0]  addr,
    output logic        step,
    output logic        sample_valid,
    output logic        mute,
    output logic        playing
);

    localparam logic [8:0]  LAST_IDX = 9'(TABLE_LEN - 1);
    localparam logic [15:0] REST_D   = 16'(REST_DIV);

    typedef enum logic {IDLE, PLAY} state_t;

    state_t      state, state_nxt;
    logic [15:0] div_q, len_q;
    logic [15:0] div_cnt, per_cnt;
    logic [8:0]  idx;
    logic [15:0] d_eff;
    logic        hs, tick, wrap, done;

    // Rest notes borrow the fixed REST_DIV timing.
    assign d_eff = (div_q == 16'd0) ? REST_D : div_q;

    // Gated by rst_n so the block never advertises ready while held in reset.
    assign note_ready = (state == IDLE) && rst_n;
    assign playing    = (state == PLAY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        hs        = 1'b0;
        tick      = 1'b0;
        wrap      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                hs = note_valid;
                // A zero-length note is consumed without leaving IDLE.
                if (note_valid && note_len != 16'd0) begin
                    state_nxt = PLAY;
                end
            end
            PLAY: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (div_cnt == d_eff - 16'd1) begin
                    tick = 1'b1;
                    if (idx == LAST_IDX) begin
                        wrap = 1'b1;
                        // per_cnt < len_q <= 65535, so the +1 cannot overflow.
                        if (per_cnt + 16'd1 == len_q) begin
                            done      = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q        <= 16'd0;
            len_q        <= 16'd0;
            div_cnt      <= 16'd0;
            per_cnt      <= 16'd0;
            idx          <= 9'd0;
            addr         <= 9'd0;
            step         <= 1'b0;
            sample_valid <= 1'b0;
            mute         <= 1'b0;
        end else begin
            // step is registered so it rises together with the new addr.
            step         <= tick;
            sample_valid <= step;
            if (hs) begin
                div_q   <= note_div;
                len_q   <= note_len;
                div_cnt <= 16'd0;
                per_cnt <= 16'd0;
                idx     <= 9'd0;
                addr    <= 9'd0;
                mute    <= (note_div == 16'd0) && (note_len != 16'd0);
            end else if (state == PLAY) begin
                if (abort || done) begin
                    div_cnt <= 16'd0;
                    idx     <= 9'd0;
                    addr    <= 9'd0;
                    mute    <= 1'b0;
                end else if (tick) begin
                    div_cnt <= 16'd0;
                    if (wrap) begin
                        idx     <= 9'd0;
                        addr    <= 9'd0;
                        per_cnt <= per_cnt + 16'd1;
                    end else begin
                        // idx is the shadow index; a rest keeps addr parked at 0.
                        idx  <= idx + 9'd1;
                        addr <= (div_q == 16'd0) ? 9'd0 : idx + 9'd1;
                    end
                end else begin
                    div_cnt <= div_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_tune_addr_gen.sv
// tb/tb_tune_addr_gen.sv - self-checking bench for tune_addr_gen
module tb_tune_addr_gen;

    localparam int TL = 213;
    localparam int RD = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        note_valid;
    logic        note_ready;
    logic [15:0] note_div;
    logic [15:0] note_len;
    logic        abort;
    logic [8:0]  addr;
    logic        step;
    logic        sample_valid;
    logic        mute;
    logic        playing;

    int checks   = 0;
    int failures = 0;

    tune_addr_gen #(.TABLE_LEN(TL), .REST_DIV(RD)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .note_valid   (note_valid),
        .note_ready   (note_ready),
        .note_div     (note_div),
        .note_len     (note_len),
        .abort        (abort),
        .addr         (addr),
        .step         (step),
        .sample_valid (sample_valid),
        .mute         (mute),
        .playing      (playing)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Present one descriptor for a single handshake cycle; on return the
    // handshake edge has passed (first PLAY cycle if len != 0).
    task automatic start_note(input int div, input int len, input string tag);
        note_valid = 1'b1;
        note_div   = 16'(div);
        note_len   = 16'(len);
        chk({tag, "_ready"}, int'(note_ready), 1);
        cyc();
        note_valid = 1'b0;
        note_div   = 16'($urandom);
        note_len   = 16'($urandom);
    endtask

    // Reference: in cycle t after PLAY entry, floor(t/D) steps have happened;
    // a step is visible whenever t is a positive multiple of D; the note lasts
    // len*TL*D cycles. Descriptor inputs are scrambled meanwhile.
    task automatic play_note(input int div, input int len, input string tag);
        int d, total, bad, first_t, steps_seen;
        int e_addr, e_step, e_play, e_mute, e_sv, prev_step;
        int o_addr, o_step, o_play, o_mute, o_sv;
        bit rest;
        rest  = (div == 0);
        d     = rest ? RD : div;
        total = len * TL * d;
        bad = 0; first_t = -1; steps_seen = 0; prev_step = 0;
        o_addr = 0; o_step = 0; o_play = 0; o_mute = 0; o_sv = 0;
        e_addr = 0; e_step = 0; e_play = 0; e_mute = 0;
        start_note(div, len, tag);
        for (int t = 0; t <= total + 1; t++) begin
            e_step = (t > 0 && t <= total && (t % d) == 0) ? 1 : 0;
            e_play = (t < total) ? 1 : 0;
            e_addr = (rest || !e_play) ? 0 : ((t / d) % TL);
            e_mute = (rest && e_play) ? 1 : 0;
            e_sv   = prev_step;
            steps_seen += int'(step);
            if (addr !== 9'(e_addr) || step !== e_step[0] || playing !== e_play[0] ||
                mute !== e_mute[0] || note_ready !== !e_play[0] ||
                (t > 0 && sample_valid !== e_sv[0])) begin
                if (bad == 0) begin
                    first_t = t;
                    o_addr = int'(addr); o_step = int'(step); o_play = int'(playing);
                    o_mute = int'(mute); o_sv = int'(sample_valid);
                end
                bad++;
            end
            prev_step = e_step;
            if (bad == 1 && first_t == t) begin
                $display("  %s first divergence t=%0d addr=%0d/%0d step=%0d/%0d play=%0d/%0d mute=%0d/%0d sv=%0d/%0d",
                         tag, t, o_addr, e_addr, o_step, e_step, o_play, e_play, o_mute, e_mute, o_sv, e_sv);
            end
            cyc();
        end
        chk({tag, "_bad_cycles"}, bad, 0);
        chk({tag, "_step_count"}, steps_seen, len * TL);
    endtask

    initial begin
        int steps, gap, entries, prev_play, sv_cnt, n;
        bit found;
        rst_n      = 1'b0;
        note_valid = 1'b0;
        note_div   = 16'd0;
        note_len   = 16'd0;
        abort      = 1'b0;
        #12;
        chk("rst_addr",  int'(addr), 0);
        chk("rst_step",  int'(step), 0);
        chk("rst_sv",    int'(sample_valid), 0);
        chk("rst_mute",  int'(mute), 0);
        chk("rst_play",  int'(playing), 0);
        chk("rst_ready", int'(note_ready), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_ready", int'(note_ready), 1);

        // Tone note over two periods; every 20 cycles a step.
        play_note(20, 2, "tone_d20_l2");
        // Rest note: one period timed by REST_DIV.
        play_note(0, 1, "rest_l1");
        // Randomised short tone notes.
        for (int i = 0; i < 4; i++) begin
            play_note(int'($urandom_range(1, 3)), int'($urandom_range(1, 2)), $sformatf("rand%0d", i));
        end

        // Zero length: consumed, no PLAY, no step.
        start_note(5, 0, "zero_len");
        chk("zero_len_play", int'(playing), 0);
        chk("zero_len_ready", int'(note_ready), 1);
        steps = 0;
        for (int i = 0; i < 4; i++) begin
            steps += int'(step) + int'(playing);
            cyc();
        end
        chk("zero_len_no_activity", steps, 0);

        // Back-to-back div=1 len=1 notes with note_valid held high.
        note_valid = 1'b1; note_div = 16'd1; note_len = 16'd1;
        steps = 0; gap = 0; entries = 0; prev_play = 0; found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            cyc();
            if (playing && !prev_play) entries++;
            if (entries == 2) note_valid = 1'b0;
            if (entries == 1) steps += int'(step);
            if (entries == 1 && !playing) begin
                gap++;
                chk("b2b_gap_ready", int'(note_ready), 1);
            end
            if (entries == 2 && !playing && prev_play) found = 1;
            prev_play = int'(playing);
        end
        note_valid = 1'b0;
        chk("b2b_done", int'(found), 1);
        chk("b2b_first_steps", steps, TL);
        chk("b2b_gap", gap, 1);
        cyc();

        // Abort at addr==57 of a div=4 note.
        start_note(4, 1, "abort");
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (addr == 9'd57) found = 1;
            else cyc();
        end
        chk("abort_reach57", int'(found), 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_play", int'(playing), 0);
        chk("abort_addr", int'(addr), 0);
        chk("abort_step", int'(step), 0);
        steps = 0; sv_cnt = int'(sample_valid);
        for (int i = 0; i < 10; i++) begin
            cyc();
            steps  += int'(step);
            sv_cnt += int'(sample_valid);
        end
        chk("abort_no_step", steps, 0);
        chk("abort_sv_at_most_once", int'(sv_cnt <= 1), 1);

        // abort held in IDLE must not block a handshake.
        abort = 1'b1;
        start_note(3, 1, "abort_idle");
        abort = 1'b0;
        chk("abort_idle_play", int'(playing), 1);
        n = 0;
        while (playing && n < 2000) begin
            cyc();
            n++;
        end
        chk("abort_idle_len", n, TL * 3);
        cyc();

        // Asynchronous reset mid-cycle during PLAY at addr==100.
        start_note(2, 1, "areset");
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (addr == 9'd100) found = 1;
            else cyc();
        end
        chk("areset_reach100", int'(found), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_addr",  int'(addr), 0);
        chk("areset_play",  int'(playing), 0);
        chk("areset_step",  int'(step), 0);
        chk("areset_sv",    int'(sample_valid), 0);
        chk("areset_mute",  int'(mute), 0);
        chk("areset_ready", int'(note_ready), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("areset_rel_ready", int'(note_ready), 1);
        chk("areset_rel_play",  int'(playing), 0);
        chk("areset_rel_addr",  int'(addr), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
